// File: rtl/fetch_if.sv
// Handshake bundle between the fetch controller and its neighbours:
// PC register, instruction memory, decode stage and redirect/halt sources.
interface fetch_if;
  logic [31:0] pc_cur;
  logic [1:0]  pc_op;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt;
  logic        trap;

  modport master (
    input  pc_cur, imem_ack, imem_rdata, imem_err, instr_ready,
           redirect_valid, redirect_target, halt,
    output pc_op, pc_next, imem_req, imem_addr, instr_valid, instr, instr_pc, trap
  );

  modport slave (
    output pc_cur, imem_ack, imem_rdata, imem_err, instr_ready,
           redirect_valid, redirect_target, halt,
    input  pc_op, pc_next, imem_req, imem_addr, instr_valid, instr, instr_pc, trap
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives the PC register, runs one imem transaction at a time,
// hands instructions to decode and handles redirects, fetch traps and halt.
//
//  state  | meaning
//  BOOT   | load RESET_VEC into the PC
//  FETCH  | imem_req high at pc_cur, waiting for ack/err/timeout
//  ISSUE  | instruction presented to decode, waiting for accept or redirect
//  REDIR  | load the redirect target latched during FETCH
//  TRAP   | load TRAP_VEC, pulse trap
//  HALTED | no fetching; redirects still load the PC
module fetch_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  fetch_if.master bus
);
  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_HOLD = 2'b10;

  typedef enum logic [2:0] {S_BOOT, S_FETCH, S_ISSUE, S_REDIR, S_TRAP, S_HALTED} state_t;

  state_t        state;
  state_t        resume;
  logic [CW-1:0] cnt;
  logic          pend;
  logic [31:0]   pend_target;
  logic [31:0]   instr_q;
  logic [31:0]   ipc_q;
  logic          valid_q;
  logic          redir_ok;
  logic          redir_bad;
  logic          pend_any;
  logic [31:0]   tgt_eff;
  logic          timeout_hit;
  logic [1:0]    pc_op_c;
  logic [31:0]   pc_next_c;

  assign redir_ok    = bus.redirect_valid && (bus.redirect_target[1:0] == 2'b00);
  assign redir_bad   = bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);
  // A redirect arriving in the ack cycle itself overrides any older pending one.
  assign pend_any    = pend || bus.redirect_valid;
  assign tgt_eff     = bus.redirect_valid ? bus.redirect_target : pend_target;
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));
  assign resume      = bus.halt ? S_HALTED : S_FETCH;

  always_comb begin
    pc_op_c   = OP_HOLD;
    pc_next_c = '0;
    if (rst_n) begin
      case (state)
        S_BOOT: begin
          pc_op_c   = OP_LOAD;
          pc_next_c = RESET_VEC;
        end
        S_ISSUE: begin
          if (redir_ok) begin
            pc_op_c   = OP_LOAD;
            pc_next_c = bus.redirect_target;
          end else if (!bus.redirect_valid && bus.instr_ready) begin
            pc_op_c = OP_INC;
          end
        end
        S_REDIR: begin
          pc_op_c   = OP_LOAD;
          pc_next_c = pend_target;
        end
        S_TRAP: begin
          pc_op_c   = OP_LOAD;
          pc_next_c = TRAP_VEC;
        end
        S_HALTED: begin
          if (redir_ok) begin
            pc_op_c   = OP_LOAD;
            pc_next_c = bus.redirect_target;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_BOOT;
      cnt         <= '0;
      pend        <= 1'b0;
      pend_target <= '0;
      instr_q     <= '0;
      ipc_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      case (state)
        S_BOOT: begin
          cnt   <= '0;
          state <= redir_bad ? S_TRAP : S_FETCH;
        end
        S_FETCH: begin
          if (bus.redirect_valid) begin
            pend        <= 1'b1;
            pend_target <= bus.redirect_target;
          end
          if (bus.imem_err || timeout_hit) begin
            state <= S_TRAP;
          end else if (bus.imem_ack) begin
            if (pend_any) begin
              state <= (tgt_eff[1:0] == 2'b00) ? S_REDIR : S_TRAP;
            end else begin
              instr_q <= bus.imem_rdata;
              ipc_q   <= bus.pc_cur;
              valid_q <= 1'b1;
              state   <= S_ISSUE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_ISSUE: begin
          cnt <= '0;
          if (bus.redirect_valid) begin
            valid_q <= 1'b0;
            state   <= redir_bad ? S_TRAP : resume;
          end else if (bus.instr_ready) begin
            valid_q <= 1'b0;
            state   <= resume;
          end
        end
        S_REDIR, S_TRAP: begin
          cnt   <= '0;
          pend  <= 1'b0;
          state <= redir_bad ? S_TRAP : resume;
        end
        S_HALTED: begin
          cnt <= '0;
          if (redir_bad)     state <= S_TRAP;
          else if (!bus.halt) state <= S_FETCH;
        end
        default: state <= S_BOOT;
      endcase
    end
  end

  assign bus.pc_op       = pc_op_c;
  assign bus.pc_next     = pc_next_c;
  assign bus.imem_req    = (state == S_FETCH);
  assign bus.imem_addr   = bus.pc_cur;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.trap        = (state == S_TRAP);
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: cycle table for the main flows, hand sequences for
// timeout/error/misaligned traps, then randomized memory timing against a scoreboard.
module tb_fetch_ctrl;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
  localparam logic [1:0]  INC = 2'b00, LD = 2'b01, HD = 2'b10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_if bus();

  fetch_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // PC register modelled by the environment
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.pc_cur <= 32'hDEAD_0000;
    else if (bus.pc_op == INC) bus.pc_cur <= bus.pc_cur + 32'd4;
    else if (bus.pc_op == LD) bus.pc_cur <= bus.pc_next;
  end

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] f(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.imem_ack = 1'b0; bus.imem_err = 1'b0; bus.imem_rdata = '0;
    bus.instr_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = '0;
    bus.halt = 1'b0;
  endtask

  typedef struct {
    logic ack; logic ready; logic rv; logic [31:0] tgt; logic halt;
    logic e_req; logic [31:0] e_addr; logic [1:0] e_op; logic [31:0] e_next;
    logic e_valid; logic [31:0] e_ipc;
  } vec_t;
  vec_t tv[$];

  task automatic add(input logic ack, input logic ready, input logic rv, input logic [31:0] tgt,
                     input logic halt, input logic e_req, input logic [31:0] e_addr,
                     input logic [1:0] e_op, input logic [31:0] e_next, input logic e_valid,
                     input logic [31:0] e_ipc);
    vec_t v;
    v.ack = ack; v.ready = ready; v.rv = rv; v.tgt = tgt; v.halt = halt;
    v.e_req = e_req; v.e_addr = e_addr; v.e_op = e_op; v.e_next = e_next;
    v.e_valid = e_valid; v.e_ipc = e_ipc;
    tv.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lat, wcnt, accepts;
    logic req_prev, exp_trap, rv, rdy, ack, err;
    logic [31:0] exp_pc, tgt;

    // ack ready rv tgt halt | req addr op next valid ipc
    add(0,0,0,0,0,     0,0,LD,0,0,0);          // BOOT
    add(0,0,0,0,0,     1,0,HD,0,0,0);
    add(1,0,0,0,0,     1,0,HD,0,0,0);
    add(0,1,0,0,0,     0,0,INC,0,1,0);
    add(0,0,0,0,0,     1,4,HD,0,0,0);
    add(1,0,0,0,0,     1,4,HD,0,0,0);
    for (int i = 0; i < 5; i++) add(0,0,0,0,0, 0,0,HD,0,1,4);   // ready low, stable
    add(0,1,0,0,0,     0,0,INC,0,1,4);
    add(0,0,0,0,0,     1,8,HD,0,0,0);
    add(1,0,0,0,0,     1,8,HD,0,0,0);
    add(0,1,1,32'h40,0, 0,0,LD,32'h40,1,8);    // redirect beats ready
    add(0,0,0,0,0,     1,32'h40,HD,0,0,0);
    add(1,0,0,0,0,     1,32'h40,HD,0,0,0);
    add(0,0,0,0,0,     0,0,HD,0,1,32'h40);
    add(0,1,0,0,0,     0,0,INC,0,1,32'h40);
    add(0,0,1,32'h80,0, 1,32'h44,HD,0,0,0);    // redirect while fetch waits
    add(0,0,0,0,0,     1,32'h44,HD,0,0,0);
    add(0,0,0,0,0,     1,32'h44,HD,0,0,0);
    add(1,0,0,0,0,     1,32'h44,HD,0,0,0);
    add(0,0,0,0,0,     0,0,LD,32'h80,0,0);     // REDIR
    add(0,0,0,0,0,     1,32'h80,HD,0,0,0);
    add(1,0,0,0,0,     1,32'h80,HD,0,0,0);
    add(0,1,0,0,0,     0,0,INC,0,1,32'h80);
    add(0,0,0,0,0,     1,32'h84,HD,0,0,0);
    add(1,0,0,0,0,     1,32'h84,HD,0,0,0);
    add(0,1,0,0,1,     0,0,INC,0,1,32'h84);    // accept with halt
    add(0,0,0,0,1,     0,0,HD,0,0,0);
    add(0,0,1,32'h20,1, 0,0,LD,32'h20,0,0);    // redirect while halted
    add(0,0,0,0,1,     0,0,HD,0,0,0);
    add(0,0,0,0,0,     0,0,HD,0,0,0);
    add(0,0,0,0,0,     1,32'h20,HD,0,0,0);

    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk1("reset req", bus.imem_req, 1'b0);
    chk("reset pc_op", 32'(bus.pc_op), 32'(HD));
    chk1("reset valid", bus.instr_valid, 1'b0);
    chk("reset instr", bus.instr, 32'h0);
    chk("reset instr_pc", bus.instr_pc, 32'h0);
    chk1("reset trap", bus.trap, 1'b0);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      bus.imem_ack = tv[i].ack;
      bus.imem_rdata = tv[i].ack ? f(tv[i].e_addr) : 32'h0;
      bus.instr_ready = tv[i].ready;
      bus.redirect_valid = tv[i].rv;
      bus.redirect_target = tv[i].tgt;
      bus.halt = tv[i].halt;
      #1;
      chk1($sformatf("row%0d req", i), bus.imem_req, tv[i].e_req);
      if (tv[i].e_req) chk($sformatf("row%0d addr", i), bus.imem_addr, tv[i].e_addr);
      chk($sformatf("row%0d pc_op", i), 32'(bus.pc_op), 32'(tv[i].e_op));
      if (tv[i].e_op == LD) chk($sformatf("row%0d pc_next", i), bus.pc_next, tv[i].e_next);
      chk1($sformatf("row%0d valid", i), bus.instr_valid, tv[i].e_valid);
      if (tv[i].e_valid) begin
        chk($sformatf("row%0d instr_pc", i), bus.instr_pc, tv[i].e_ipc);
        chk($sformatf("row%0d instr", i), bus.instr, f(tv[i].e_ipc));
      end
      chk1($sformatf("row%0d trap", i), bus.trap, 1'b0);
      tick();
    end

    // Timeout: the last table row was the first cycle of a fetch at 0x20
    idle();
    n = 1;
    while (bus.imem_req && n < 40) begin
      n++;
      tick();
    end
    chk("timeout req cycles", 32'(n), 32'd16);
    chk1("timeout trap", bus.trap, 1'b1);
    chk1("timeout req low", bus.imem_req, 1'b0);
    chk("timeout pc_op", 32'(bus.pc_op), 32'(LD));
    chk("timeout pc_next", bus.pc_next, TRAP_VEC);
    tick();
    chk1("timeout trap pulse", bus.trap, 1'b0);
    chk1("timeout refetch req", bus.imem_req, 1'b1);
    chk("timeout refetch addr", bus.imem_addr, TRAP_VEC);

    // Bus error
    tick();
    bus.imem_err = 1'b1;
    #1;
    chk1("err req", bus.imem_req, 1'b1);
    tick();
    bus.imem_err = 1'b0;
    chk1("err trap", bus.trap, 1'b1);
    chk("err pc_next", bus.pc_next, TRAP_VEC);
    tick();
    chk1("err trap pulse", bus.trap, 1'b0);
    chk("err refetch addr", bus.imem_addr, TRAP_VEC);

    // Misaligned redirect during a fetch traps once the fetch completes
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h42;
    #1;
    tick();
    bus.redirect_valid = 1'b0;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = f(TRAP_VEC);
    #1;
    chk1("misalign req held", bus.imem_req, 1'b1);
    tick();
    bus.imem_ack = 1'b0;
    chk1("misalign trap", bus.trap, 1'b1);
    chk1("misalign valid", bus.instr_valid, 1'b0);
    chk("misalign pc_next", bus.pc_next, TRAP_VEC);
    tick();
    chk("misalign refetch addr", bus.imem_addr, TRAP_VEC);

    // Randomized memory latency, ready, redirects and errors
    exp_pc = TRAP_VEC;
    exp_trap = 1'b0;
    req_prev = 1'b0;
    lat = 0; wcnt = 0; accepts = 0;
    for (int c = 0; c < 3000; c++) begin
      ack = 1'b0; err = 1'b0; rv = 1'b0; tgt = '0;
      chk1("rand trap", bus.trap, exp_trap);
      exp_trap = 1'b0;
      if (bus.imem_req) begin
        if (!req_prev) begin
          lat = $urandom_range(0, 4);
          wcnt = 0;
          chk("rand fetch addr", bus.imem_addr, exp_pc);
        end
        if (wcnt == lat) begin
          if ($urandom_range(0, 15) == 0) err = 1'b1;
          else ack = 1'b1;
        end
        wcnt++;
      end
      req_prev = bus.imem_req;
      if ((bus.imem_req || bus.instr_valid) && $urandom_range(0, 9) == 0) begin
        rv = 1'b1;
        tgt = $urandom & 32'h0000_0FFC;
      end
      rdy = 1'($urandom_range(0, 1));
      bus.imem_ack = ack;
      bus.imem_err = err;
      bus.imem_rdata = f(bus.imem_addr);
      bus.redirect_valid = rv;
      bus.redirect_target = tgt;
      bus.instr_ready = rdy;
      if (rv) exp_pc = tgt;
      if (err) begin
        exp_pc = TRAP_VEC;
        exp_trap = 1'b1;
      end
      if (bus.instr_valid && rdy && !rv) begin
        chk("rand instr_pc", bus.instr_pc, exp_pc);
        chk("rand instr", bus.instr, f(exp_pc));
        exp_pc = exp_pc + 32'd4;
        accepts++;
      end
      tick();
    end
    chk1("rand progress", accepts > 100, 1'b1);

    // Reset in the middle of activity
    idle();
    rst_n = 1'b0;
    #1;
    chk1("midreset req", bus.imem_req, 1'b0);
    chk1("midreset valid", bus.instr_valid, 1'b0);
    chk("midreset pc_op", 32'(bus.pc_op), 32'(HD));
    tick();
    rst_n = 1'b1;
    #1;
    chk("reboot pc_op", 32'(bus.pc_op), 32'(LD));
    chk("reboot pc_next", bus.pc_next, 32'h0);
    tick();
    chk1("reboot req", bus.imem_req, 1'b1);
    chk("reboot addr", bus.imem_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
